// File: rtl/exe_scoreboard.sv
// Execute-stage register scoreboard: blocks issue on RAW/WAW hazards, sequences drains, honours flush.
// Optional SB_PERF_EN builds a saturating issue-stall counter on stall_cnt.
module exe_scoreboard #(
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rs1,
    input  logic [RW-1:0]   issue_rs2,
    input  logic            issue_rs1_used,
    input  logic            issue_rs2_used,
    input  logic [RW-1:0]   issue_rd,
    input  logic            issue_we,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic            flush,
    input  logic            drain_req,
    output logic            drain_done,
    output logic [NREG-1:0] busy_mask,
    output logic [RW:0]     outstanding,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic          raw1, raw2, waw, fire;
    logic [NREG-1:0] pend_nxt;
    logic [RW:0]     cnt_nxt;

    // Hazards use only the registered pending bits; a same-cycle writeback does not bypass.
    assign raw1 = issue_rs1_used && (issue_rs1 != '0) && busy_mask[issue_rs1];
    assign raw2 = issue_rs2_used && (issue_rs2 != '0) && busy_mask[issue_rs2];
    assign waw  = issue_we && (issue_rd != '0) && busy_mask[issue_rd];

    // Handshake: an instruction transfers on a cycle where issue_valid && issue_ready;
    // issue_ready never depends on issue_valid, and the issuer holds its fields until transfer.
    assign issue_ready = (state == S_RUN) && !drain_req && !flush && !raw1 && !raw2 && !waw;
    assign fire        = issue_valid && issue_ready;

    always_comb begin
        pend_nxt = busy_mask;
        if (wb_valid && (wb_rd != '0))
            pend_nxt[wb_rd] = 1'b0;
        if (fire && issue_we && (issue_rd != '0))
            pend_nxt[issue_rd] = 1'b1;
        if (flush)
            pend_nxt = '0;
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++)
            cnt_nxt = cnt_nxt + (RW+1)'(pend_nxt[i]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_RUN;
            drain_done  <= 1'b0;
            busy_mask   <= '0;
            outstanding <= '0;
        end else begin
            busy_mask   <= pend_nxt;
            outstanding <= cnt_nxt;
            case (state)
                S_RUN: begin
                    drain_done <= 1'b0;
                    if (drain_req)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A flush empties the pipe by itself, so it completes the drain directly.
                    if ((outstanding == '0) || flush) begin
                        state      <= S_DONE;
                        drain_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_RUN;
                    drain_done <= 1'b0;
                end
                default: begin
                    state      <= S_RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef SB_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            stall_cnt <= '0;
        else if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_scoreboard.sv
// Bench for exe_scoreboard: directed scenarios plus random traffic against a set-based reference model.
module tb_exe_scoreboard;

    localparam int NREG = 32;
    localparam int RW   = 5;
`ifdef SB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

    logic            clk, nrst;
    logic            issue_valid, issue_rs1_used, issue_rs2_used, issue_we;
    logic [RW-1:0]   issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic            issue_ready, wb_valid, flush, drain_req, drain_done;
    logic [NREG-1:0] busy_mask;
    logic [RW:0]     outstanding;
    logic [15:0]     stall_cnt;

    exe_scoreboard #(.NREG(NREG), .RW(RW)) dut (
        .clk(clk), .nrst(nrst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_we(issue_we), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .drain_req(drain_req),
        .drain_done(drain_done), .busy_mask(busy_mask), .outstanding(outstanding),
        .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: set of pending registers, drain mode, stall count
    bit          m_pend[NREG];
    int          m_mode;
    int          m_stall;
    logic [31:0] exp_q[$];
    int          n_cmp, n_err;
    logic [31:0] obs_busy, obs_stall;
    logic        obs_ready, obs_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rs1_used = 0; issue_rs2_used = 0;
        issue_rd = '0; issue_we = 0; wb_valid = 0; wb_rd = '0; flush = 0; drain_req = 0;
    endtask

    task automatic present(input int rd, input bit we, input int rs1, input bit u1,
                           input int rs2, input bit u2);
        issue_valid = 1; issue_rd = RW'(rd); issue_we = we;
        issue_rs1 = RW'(rs1); issue_rs1_used = u1; issue_rs2 = RW'(rs2); issue_rs2_used = u2;
    endtask

    task automatic do_reset();
        idle();
        nrst = 0;
        for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        m_mode = M_RUN; m_stall = 0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", busy_mask, 0);
            check("rst_outst", 32'(outstanding), 0);
            check("rst_done", 32'(drain_done), 0);
            check("rst_stall", 32'(stall_cnt), 0);
            check("rst_ready", 32'(issue_ready), 1);
        end
        nrst = 1;
        @(posedge clk); #1;
        exp_q.push_back(0);
    endtask

    // One clock cycle: compare DUT outputs with the model at negedge, then advance the model.
    task automatic step();
        int          cnt;
        bit          haz, ready;
        logic [31:0] exp_mask;
        @(negedge clk);
        cnt = 0;
        for (int i = 1; i < NREG; i++) if (m_pend[i]) cnt++;
        haz = (issue_rs1_used && issue_rs1 != 0 && m_pend[issue_rs1]) ||
              (issue_rs2_used && issue_rs2 != 0 && m_pend[issue_rs2]) ||
              (issue_we && issue_rd != 0 && m_pend[issue_rd]);
        ready = (m_mode == M_RUN) && !drain_req && !flush && !haz;
        check("ready", 32'(issue_ready), 32'(ready));
        if (exp_q.size() == 0) check("busy_q_empty", 1, 0);
        else check("busy", busy_mask, exp_q.pop_front());
        check("outst", 32'(outstanding), cnt);
        check("done", 32'(drain_done), 32'(m_mode == M_DONE));
        check("stall", 32'(stall_cnt), m_stall);
        obs_busy = busy_mask; obs_stall = 32'(stall_cnt);
        obs_ready = issue_ready; obs_done = drain_done;
        if (PERF && issue_valid && !ready && m_stall < 65535) m_stall++;
        case (m_mode)
            M_RUN:   if (drain_req) m_mode = M_DRAIN;
            M_DRAIN: if (cnt == 0 || flush) m_mode = M_DONE;
            default: m_mode = M_RUN;
        endcase
        if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 0;
        if (issue_valid && ready && issue_we && issue_rd != 0) m_pend[issue_rd] = 1;
        if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        exp_mask = 0;
        for (int i = 1; i < NREG; i++) exp_mask[i] = m_pend[i];
        exp_q.push_back(exp_mask);
        @(posedge clk); #1;
    endtask

    initial begin
        int ndone;
        n_cmp = 0; n_err = 0;
        nrst = 0;
        do_reset();

        // RAW on x5
        present(5, 1, 0, 0, 0, 0); step();
        present(0, 0, 5, 1, 0, 0); step();
        check("t1_busy", obs_busy, 32'h20);
        check("t1_blocked", 32'(obs_ready), 0);
        wb_valid = 1; wb_rd = 5; step();
        check("t1_nobypass", 32'(obs_ready), 0);
        wb_valid = 0; step();
        check("t1_ready", 32'(obs_ready), 1);

        // x0 never pending
        present(0, 1, 0, 0, 0, 0); step();
        present(0, 0, 0, 1, 0, 1); step();
        check("t2_busy", obs_busy, 0);
        check("t2_ready", 32'(obs_ready), 1);

        // WAW on x3 with x7 also pending
        present(3, 1, 0, 0, 0, 0); step();
        present(7, 1, 0, 0, 0, 0); step();
        present(3, 1, 0, 0, 0, 0); step();
        check("t3_waw", 32'(obs_ready), 0);
        wb_valid = 1; wb_rd = 7; step();
        wb_valid = 0; step();
        check("t3_still", 32'(obs_ready), 0);
        wb_valid = 1; wb_rd = 3; step();
        wb_valid = 0; step();
        check("t3_ready", 32'(obs_ready), 1);

        // drain with {3,7} pending
        present(7, 1, 0, 0, 0, 0); step();
        issue_valid = 0; drain_req = 1; step();
        drain_req = 0; present(10, 1, 0, 0, 0, 0); step();
        check("t4_drain_blk", 32'(obs_ready), 0);
        issue_valid = 0;
        wb_valid = 1; wb_rd = 3; step();
        wb_rd = 7; step();
        wb_valid = 0;
        ndone = 0;
        repeat (5) begin step(); if (obs_done) ndone++; end
        check("t4_done_once", ndone, 1);

        // flush beats a simultaneous fire
        do_reset();
        present(4, 1, 0, 0, 0, 0); step();
        present(9, 1, 0, 0, 0, 0); flush = 1; step();
        check("t5_flush_blk", 32'(obs_ready), 0);
        flush = 0; issue_valid = 0; step();
        check("t5_busy", obs_busy, 0);

        // reset in the middle of a drain
        present(4, 1, 0, 0, 0, 0); step();
        issue_valid = 0; drain_req = 1; step();
        drain_req = 0; step();
        do_reset();
        present(4, 1, 0, 0, 0, 0); step();
        check("t5_rst_ready", 32'(obs_ready), 1);
        check("t5_rst_nodone", 32'(obs_done), 0);

        // stall counter: 10 blocked cycles, then saturation
        do_reset();
        present(5, 1, 0, 0, 0, 0); step();
        present(0, 0, 5, 1, 0, 0);
        repeat (10) step();
        issue_valid = 0; step();
        check("t6_stall10", obs_stall, PERF ? 10 : 0);
        present(0, 0, 5, 1, 0, 0);
        repeat (65600) step();
        issue_valid = 0; step();
        check("t6_stall_sat", obs_stall, PERF ? 32'hFFFF : 0);

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs1      = RW'($urandom_range(0, 7));
            issue_rs2      = RW'($urandom_range(0, 7));
            issue_rs1_used = $urandom_range(0, 1);
            issue_rs2_used = $urandom_range(0, 1);
            issue_rd       = RW'($urandom_range(0, 9));
            issue_we       = $urandom_range(0, 1);
            wb_valid       = ($urandom_range(0, 2) == 0);
            wb_rd          = RW'($urandom_range(0, 9));
            flush          = ($urandom_range(0, 40) == 0);
            drain_req      = ($urandom_range(0, 25) == 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
